// File: rtl/mem_pkg.sv
// Shared definitions for the line-transfer bus: opcodes, geometry, responder FSM states.
package mem_pkg;

    localparam int LINE_WORDS    = 16;
    localparam int WORD_W        = 32;
    localparam int LINE_OFF_BITS = 6;
    localparam int BEAT_W        = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_RD  = 2'b01,
        OP_WR  = 2'b11
    } mem_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_BURST,
        S_WR_BURST
    } resp_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Line-transfer bus between the initiator (master) and the memory responder (slave).
interface mem_responder_if;
    import mem_pkg::*;

    // op stays a raw 2-bit field: 2'b10 is a legal no-op with no enum member
    logic [1:0]        op;
    logic [63:0]       io_address;
    logic [WORD_W-1:0] common_data_bus_in;
    logic [WORD_W-1:0] common_data_bus_out;
    logic              rd_valid;
    logic              tx_done;

    modport master (
        output op, io_address, common_data_bus_in,
        input  common_data_bus_out, rd_valid, tx_done
    );

    modport slave (
        input  op, io_address, common_data_bus_in,
        output common_data_bus_out, rd_valid, tx_done
    );

endinterface

// File: rtl/line_ram.sv
// Single-port word RAM, synchronous read with one-cycle latency, no reset.
module line_ram
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Write has priority; a read only refreshes rdata when requested
    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        else if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: serves 16-word line reads and absorbs 16-word line writes.
module mem_responder
    import mem_pkg::*;
#(
    parameter int LINES      = 64,
    parameter int RD_LATENCY = 2
) (
    input logic           clk,
    input logic           rst,
    mem_responder_if.slave bus
);

    localparam int LINE_BITS = $clog2(LINES);
    localparam int WAIT_W    = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LATENCY - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LINE_WORDS - 1);

    resp_state_t          state, state_nxt;
    logic [BEAT_W-1:0]    beat, beat_nxt;
    logic [WAIT_W-1:0]    wcnt, wcnt_nxt;
    logic [LINE_BITS-1:0] line, line_nxt;
    logic                 ram_we, ram_re;
    logic [BEAT_W-1:0]    ram_beat;
    logic [WORD_W-1:0]    ram_q;
    logic                 unused_addr;

    // Offset bits and high aliasing bits are don't-care by design
    assign unused_addr = ^bus.io_address;

    // State, beat counter, wait counter and latched line index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            beat  <= '0;
            wcnt  <= '0;
            line  <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            wcnt  <= wcnt_nxt;
            line  <= line_nxt;
        end
    end

    // Next state and RAM control; the read address runs one beat ahead of the data
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        wcnt_nxt  = wcnt;
        line_nxt  = line;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_beat  = beat;
        case (state)
            S_IDLE: begin
                if (bus.op == 2'(OP_RD) || bus.op == 2'(OP_WR)) begin
                    line_nxt  = bus.io_address[LINE_OFF_BITS +: LINE_BITS];
                    beat_nxt  = '0;
                    wcnt_nxt  = '0;
                    state_nxt = (bus.op == 2'(OP_RD)) ? S_RD_WAIT : S_WR_BURST;
                end
            end
            S_RD_WAIT: begin
                if (wcnt == WAIT_LAST) begin
                    ram_re    = 1'b1;
                    state_nxt = S_RD_BURST;
                end else begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            S_RD_BURST: begin
                ram_re   = 1'b1;
                ram_beat = beat + 1'b1;
                beat_nxt = beat + 1'b1;
                if (beat == BEAT_LAST)
                    state_nxt = S_IDLE;
            end
            S_WR_BURST: begin
                ram_we   = 1'b1;
                beat_nxt = beat + 1'b1;
                if (beat == BEAT_LAST)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    line_ram #(
        .DEPTH (LINES * LINE_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  ({line, ram_beat}),
        .wdata (bus.common_data_bus_in),
        .rdata (ram_q)
    );

    // Moore outputs; data is forced to zero outside read beats
    assign bus.rd_valid            = (state == S_RD_BURST);
    assign bus.tx_done             = (state == S_RD_BURST || state == S_WR_BURST) && (beat == BEAT_LAST);
    assign bus.common_data_bus_out = bus.rd_valid ? ram_q : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: bursts, turnaround, no-ops, reset, aliasing, latency sweep.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int L = 2;
    typedef logic [31:0] line_t [16];

    logic clk = 1'b0;
    logic rst, rst_sw;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_responder_if bus();
    mem_responder_if b1();
    mem_responder_if b5();

    mem_responder #(.LINES(64), .RD_LATENCY(L)) dut (.clk(clk), .rst(rst),    .bus(bus));
    mem_responder #(.LINES(64), .RD_LATENCY(1)) u1  (.clk(clk), .rst(rst_sw), .bus(b1));
    mem_responder #(.LINES(64), .RD_LATENCY(5)) u5  (.clk(clk), .rst(rst_sw), .bus(b5));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each step lands 1 time unit after a rising edge: drive and sample point
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept at cycle 0; word k is on the bus during cycle k+1 (word 0 also on cycle 0)
    task automatic wr_line(input logic [63:0] a, input line_t d, input string tag);
        int early = 0;
        bus.op = 2'b11;
        bus.io_address = a;
        bus.common_data_bus_in = d[0];
        for (int c = 1; c <= 16; c++) begin
            step();
            bus.op = 2'b00;
            bus.io_address = 64'hFFFF_FFFF_FFFF_FFC0;
            bus.common_data_bus_in = d[c-1];
            if (c < 16 && (bus.tx_done !== 1'b0 || bus.rd_valid !== 1'b0)) early++;
            if (c == 16) chk({tag, "/done@16"}, 64'(bus.tx_done), 64'd1);
        end
        chk({tag, "/early_done"}, 64'(early), 64'd0);
        step();
        chk({tag, "/idle@17"}, 64'(bus.tx_done), 64'd0);
    endtask

    // Accept at cycle 0; beats at L+1..L+16, done at L+16, back in IDLE at L+17
    task automatic rd_line(input logic [63:0] a, input line_t exp, input bit noise,
                           output line_t cap, input string tag);
        int bad = 0, nv = 0, nd = 0;
        bit ev, et;
        logic [31:0] ed;
        bus.op = 2'b01;
        bus.io_address = a;
        for (int c = 1; c <= L + 17; c++) begin
            step();
            bus.op = (noise && c <= L + 14) ? 2'b11 : 2'b00;
            bus.io_address = noise ? 64'h0 : a;
            bus.common_data_bus_in = 32'hDEAD_0000 + 32'(c);
            ev = (c >= L + 1) && (c <= L + 16);
            et = (c == L + 16);
            ed = ev ? exp[c-L-1] : 32'h0;
            if (bus.rd_valid === 1'b1) nv++;
            if (bus.tx_done === 1'b1) nd++;
            if (ev) cap[c-L-1] = bus.common_data_bus_out;
            if (bus.rd_valid !== ev || bus.tx_done !== et || bus.common_data_bus_out !== ed) bad++;
        end
        chk({tag, "/bad_cycles"}, 64'(bad), 64'd0);
        chk({tag, "/valid_cnt"}, 64'(nv), 64'd16);
        chk({tag, "/done_cnt"}, 64'(nd), 64'd1);
    endtask

    line_t la, lp, lal, cap, cap2;
    int    busy, f1, f5, v1, v5, d1, d5;

    initial begin
        for (int k = 0; k < 16; k++) begin
            la[k]  = 32'hA0 + 32'(k);
            lp[k]  = 32'h1000 + 32'(k);
            lal[k] = 32'h5500_0000 + 32'(k * 3);
        end
        rst = 1'b1;
        rst_sw = 1'b1;
        bus.op = 2'b00; bus.io_address = '0; bus.common_data_bus_in = '0;
        b1.op = 2'b00;  b1.io_address = '0;  b1.common_data_bus_in = '0;
        b5.op = 2'b00;  b5.io_address = '0;  b5.common_data_bus_in = '0;
        #1;
        chk("reset/rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("reset/tx_done", 64'(bus.tx_done), 64'd0);
        chk("reset/data", 64'(bus.common_data_bus_out), 64'd0);
        step(); step();
        rst = 1'b0;
        rst_sw = 1'b0;
        step();

        // Write then read, back-to-back turnaround
        wr_line(64'h400, la, "wr_a0");
        rd_line(64'h400, la, 1'b0, cap, "rd_a0");

        // No-ops must neither respond nor disturb the RAM
        busy = 0;
        for (int c = 0; c < 20; c++) begin
            bus.op = (c < 10) ? 2'b00 : 2'b10;
            bus.io_address = 64'h400;
            step();
            if (bus.rd_valid !== 1'b0 || bus.tx_done !== 1'b0) busy++;
        end
        bus.op = 2'b00;
        chk("noop/activity", 64'(busy), 64'd0);
        rd_line(64'h400, la, 1'b1, cap, "rd_after_noop");

        // Loopback: line 0 read out and written back to line 16
        wr_line(64'h0, lp, "wr_line0");
        rd_line(64'h0, lp, 1'b0, cap, "rd_line0");
        wr_line(64'h400, cap, "wr_copy");
        rd_line(64'h400, lp, 1'b0, cap2, "rd_copy");

        // Reset during read beat 7
        bus.op = 2'b01;
        bus.io_address = 64'h400;
        for (int c = 1; c <= L + 8; c++) begin
            step();
            bus.op = 2'b00;
        end
        chk("rst_mid/beat7_valid", 64'(bus.rd_valid), 64'd1);
        chk("rst_mid/beat7_data", 64'(bus.common_data_bus_out), 64'(lp[7]));
        rst = 1'b1;
        #1;
        chk("rst_mid/rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst_mid/tx_done", 64'(bus.tx_done), 64'd0);
        chk("rst_mid/data", 64'(bus.common_data_bus_out), 64'd0);
        step(); step();
        rst = 1'b0;
        step();
        rd_line(64'h400, lp, 1'b0, cap, "rd_after_rst");

        // Aliasing: 0x1400 maps to line 16, offset bits of 0x43C ignored
        wr_line(64'h1400, lal, "wr_alias");
        rd_line(64'h43C, lal, 1'b0, cap, "rd_alias");

        // Latency sweep on the L=1 and L=5 instances in parallel
        f1 = 0; f5 = 0; v1 = 0; v5 = 0; d1 = 0; d5 = 0;
        b1.op = 2'b01;
        b5.op = 2'b01;
        for (int c = 1; c <= 30; c++) begin
            step();
            b1.op = 2'b00;
            b5.op = 2'b00;
            if (b1.rd_valid === 1'b1) begin if (v1 == 0) f1 = c; v1++; end
            if (b5.rd_valid === 1'b1) begin if (v5 == 0) f5 = c; v5++; end
            if (b1.tx_done === 1'b1) d1++;
            if (b5.tx_done === 1'b1) d5++;
        end
        chk("lat1/first_beat", 64'(f1), 64'd2);
        chk("lat1/valid_cnt", 64'(v1), 64'd16);
        chk("lat1/done_cnt", 64'(d1), 64'd1);
        chk("lat5/first_beat", 64'(f5), 64'd6);
        chk("lat5/valid_cnt", 64'(v5), 64'd16);
        chk("lat5/done_cnt", 64'(d5), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
